// File: rtl/ssd_scan_multiplexer_if.sv
// Bus between core logic and the seven-segment scan driver.
// load is a one-cycle strobe with no ready: the driver samples the four input vectors on every cycle load is high.
interface ssd_scan_multiplexer_if #(
    parameter int NUM_DIGITS = 8,
    parameter int PWM_BITS   = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   enable_in;
    logic [NUM_DIGITS-1:0]   blink_in;
    logic [PWM_BITS-1:0]     brightness;
    logic [NUM_DIGITS-1:0]   an_out;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_sync;

    modport master (
        output load, digits_in, dp_in, enable_in, blink_in, brightness,
        input  an_out, seg_out, dp_out, digit_idx, frame_sync
    );

    modport slave (
        input  load, digits_in, dp_in, enable_in, blink_in, brightness,
        output an_out, seg_out, dp_out, digit_idx, frame_sync
    );
endinterface

// File: rtl/ssd_scan_multiplexer.sv
// Time-multiplexed seven-segment driver: per-digit enable/dp/blink, PWM brightness,
// anti-ghost blanking and a double-buffered load that only takes effect at frame boundaries.
module ssd_scan_multiplexer #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_BITS    = 18,
    parameter int PWM_BITS     = 4,
    parameter int BLINK_BITS   = 26,
    parameter int BLANK_CYCLES = 4
) (
    input logic                  board_clk,
    input logic                  Reset,
    ssd_scan_multiplexer_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int LOW_W = SCAN_BITS - PWM_BITS;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   en;
        logic [NUM_DIGITS-1:0]   bl;
    } disp_buf_t;

    logic [SCAN_BITS-1:0]  prescaler;
    logic [IDX_W-1:0]      idx;
    logic [BLINK_BITS-1:0] blink_cnt;
    disp_buf_t             staging, active, in_buf;
    logic                  pending;
    logic                  slot_end, frame_tick;

    logic [3:0]            cur_nib;
    logic                  cur_en, cur_bl, cur_dp, visible;
    logic [PWM_BITS-1:0]   pw;
    logic [LOW_W-1:0]      sub;
    logic [NUM_DIGITS-1:0] an_nxt, an_q;
    logic [6:0]            seg_q;
    logic                  dp_q, fs_q;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b0000001;  4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;  4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;  4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;  4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;  4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;  default: hex7 = 7'b0111000;
        endcase
    endfunction

    assign in_buf     = '{digits: bus.digits_in, dp: bus.dp_in, en: bus.enable_in, bl: bus.blink_in};
    assign slot_end   = &prescaler;
    assign frame_tick = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            prescaler <= '0;
            idx       <= '0;
            blink_cnt <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
            if (slot_end)
                idx <= frame_tick ? '0 : idx + 1'b1;
        end
    end

    // A load landing on the boundary cycle bypasses staging so it is not delayed a whole frame.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            staging <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else if (bus.load) begin
            staging <= in_buf;
            if (frame_tick) begin
                active  <= in_buf;
                pending <= 1'b0;
            end else begin
                pending <= 1'b1;
            end
        end else if (frame_tick && pending) begin
            active  <= staging;
            pending <= 1'b0;
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_en  = 1'b0;
        cur_bl  = 1'b0;
        cur_dp  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib = active.digits[4*i +: 4];
                cur_en  = active.en[i];
                cur_bl  = active.bl[i];
                cur_dp  = active.dp[i];
            end
        end
    end

    // Blank window covers only the first PWM step so it never eats into higher duty steps.
    assign pw      = prescaler[SCAN_BITS-1 -: PWM_BITS];
    assign sub     = prescaler[LOW_W-1:0];
    assign visible = cur_en && !(cur_bl && blink_cnt[BLINK_BITS-1])
                     && ((sub >= LOW_W'(BLANK_CYCLES)) || (pw != '0))
                     && (pw <= bus.brightness);

    always_comb begin
        an_nxt = '1;
        for (int i = 0; i < NUM_DIGITS; i++)
            an_nxt[i] = ~(visible && (idx == IDX_W'(i)));
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            an_q  <= '1;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
            fs_q  <= 1'b0;
        end else begin
            an_q  <= an_nxt;
            seg_q <= visible ? hex7(cur_nib) : 7'h7F;
            dp_q  <= visible ? ~cur_dp : 1'b1;
            fs_q  <= frame_tick;
        end
    end

    assign bus.an_out     = an_q;
    assign bus.seg_out    = seg_q;
    assign bus.dp_out     = dp_q;
    assign bus.frame_sync = fs_q;
    assign bus.digit_idx  = idx;
endmodule

// File: tb/tb_ssd_scan_multiplexer.sv
// Directed + random bench for ssd_scan_multiplexer; expected pins come from a cycle-count
// reference model (slot = n/16, blink = n%256, frame boundary every 80 clocks).
module tb_ssd_scan_multiplexer;
    localparam int ND    = 5;
    localparam int SB    = 4;
    localparam int PB    = 2;
    localparam int BB    = 8;
    localparam int BC    = 1;
    localparam int SLOT  = 1 << SB;
    localparam int FRAME = SLOT * ND;
    localparam int BLINK = 1 << BB;

    logic board_clk = 1'b0;
    logic Reset     = 1'b0;
    always #5 board_clk = ~board_clk;

    ssd_scan_multiplexer_if #(.NUM_DIGITS(ND), .PWM_BITS(PB)) bus_if();

    ssd_scan_multiplexer #(
        .NUM_DIGITS(ND), .SCAN_BITS(SB), .PWM_BITS(PB),
        .BLINK_BITS(BB), .BLANK_CYCLES(BC)
    ) dut (
        .board_clk(board_clk),
        .Reset(Reset),
        .bus(bus_if.slave)
    );

    int tests = 0;
    int fails = 0;

    logic [6:0] hex_tab [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model state: n = clocks since reset release.
    int              n;
    logic [4*ND-1:0] a_dig, s_dig;
    logic [ND-1:0]   a_dp, a_en, a_bl, s_dp, s_en, s_bl;
    bit              pend;
    logic [16:0]     exp_q[$];
    int              lit_cnt[ND];
    int              fs_cnt, dp_lit, dp_stray;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        a_dig = '0; a_dp = '0; a_en = '0; a_bl = '0;
        s_dig = '0; s_dp = '0; s_en = '0; s_bl = '0;
        pend = 0;
        exp_q.delete();
    endtask

    task automatic clear_counts();
        for (int i = 0; i < ND; i++) lit_cnt[i] = 0;
        fs_cnt = 0; dp_lit = 0; dp_stray = 0;
    endtask

    task automatic tick();
        int d, p, pw, lo;
        bit bph, vis, fb;
        logic [ND-1:0] one, e_an;
        logic [6:0] e_seg;
        logic e_dp;
        logic [2:0] e_idx;
        logic [16:0] e;
        @(posedge board_clk);
        d   = (n / SLOT) % ND;
        p   = n % SLOT;
        pw  = p >> (SB - PB);
        lo  = p % (1 << (SB - PB));
        bph = (n % BLINK) >= (BLINK / 2);
        fb  = (n % FRAME) == (FRAME - 1);
        vis = a_en[d] && !(a_bl[d] && bph) && (lo >= BC || pw != 0) && (pw <= int'(bus_if.brightness));
        one   = 1;
        e_an  = vis ? ~(one << d) : '1;
        e_seg = vis ? hex_tab[a_dig[4*d +: 4]] : 7'h7F;
        e_dp  = vis ? ~a_dp[d] : 1'b1;
        e_idx = 3'(((n + 1) / SLOT) % ND);
        exp_q.push_back({e_an, e_seg, e_dp, fb, e_idx});
        if (bus_if.load) begin
            s_dig = bus_if.digits_in; s_dp = bus_if.dp_in;
            s_en  = bus_if.enable_in; s_bl = bus_if.blink_in;
            if (fb) begin
                a_dig = s_dig; a_dp = s_dp; a_en = s_en; a_bl = s_bl;
                pend = 0;
            end else begin
                pend = 1;
            end
        end else if (fb && pend) begin
            a_dig = s_dig; a_dp = s_dp; a_en = s_en; a_bl = s_bl;
            pend = 0;
        end
        n++;
        #1;
        e = exp_q.pop_front();
        chk("an_out", bus_if.an_out, e[16:12]);
        chk("seg_out", bus_if.seg_out, e[11:5]);
        chk("dp_out", bus_if.dp_out, e[4]);
        chk("frame_sync", bus_if.frame_sync, e[3]);
        chk("digit_idx", bus_if.digit_idx, e[2:0]);
        chk("one_anode_low", $countones(~bus_if.an_out) <= 1, 1);
        for (int i = 0; i < ND; i++)
            if (bus_if.an_out[i] === 1'b0) lit_cnt[i]++;
        if (bus_if.frame_sync === 1'b1) fs_cnt++;
        if (bus_if.dp_out === 1'b0) dp_lit++;
        if (bus_if.dp_out === 1'b0 && bus_if.an_out[1] !== 1'b0) dp_stray++;
    endtask

    task automatic run_to(input int m, input int t);
        while ((n % m) != t) tick();
    endtask

    task automatic do_load(input logic [4*ND-1:0] dg, input logic [ND-1:0] dp,
                           input logic [ND-1:0] en, input logic [ND-1:0] bl);
        bus_if.digits_in = dg; bus_if.dp_in = dp;
        bus_if.enable_in = en; bus_if.blink_in = bl;
        bus_if.load = 1'b1;
        tick();
        bus_if.load = 1'b0;
        bus_if.digits_in = 20'($urandom);
        bus_if.dp_in     = 5'($urandom);
        bus_if.enable_in = 5'($urandom);
        bus_if.blink_in  = 5'($urandom);
    endtask

    task automatic check_off(input string tag);
        chk({tag, "_an"}, bus_if.an_out, 5'h1F);
        chk({tag, "_seg"}, bus_if.seg_out, 7'h7F);
        chk({tag, "_dp"}, bus_if.dp_out, 1'b1);
        chk({tag, "_fs"}, bus_if.frame_sync, 1'b0);
        chk({tag, "_idx"}, bus_if.digit_idx, 3'd0);
    endtask

    initial begin
        int exp2;
        bus_if.load = 1'b0; bus_if.digits_in = '0; bus_if.dp_in = '0;
        bus_if.enable_in = '0; bus_if.blink_in = '0; bus_if.brightness = 2'd3;
        model_reset();
        clear_counts();

        // Power-on reset.
        Reset = 1'b1;
        repeat (2) @(posedge board_clk);
        #1 check_off("reset");
        @(negedge board_clk) Reset = 1'b0;
        model_reset();

        // Full brightness, digits 0..4 show 0,1,2,3,4.
        do_load(20'h43210, 5'h00, 5'h1F, 5'h00);
        run_to(FRAME, 0);
        clear_counts();
        repeat (FRAME) tick();
        for (int i = 0; i < ND; i++) chk("lit_full", lit_cnt[i], 15);
        chk("fs_per_frame", fs_cnt, 1);
        run_to(FRAME, 1); tick();
        chk("seg_d0", bus_if.seg_out, 7'b0000001);
        run_to(FRAME, SLOT + 1); tick();
        chk("seg_d1", bus_if.seg_out, 7'b1001111);

        // Asynchronous reset in the middle of digit 3's slot.
        run_to(FRAME, 3 * SLOT + 7);
        #2 Reset = 1'b1;
        #1 check_off("midreset");
        @(posedge board_clk);
        @(negedge board_clk) Reset = 1'b0;
        model_reset();
        chk("idx_after_reset", bus_if.digit_idx, 3'd0);
        do_load(20'h43210, 5'h00, 5'h1F, 5'h00);
        run_to(FRAME, 0);

        // Mid-frame load holds the old value until the boundary.
        run_to(FRAME, 4);
        do_load(20'h4321F, 5'h00, 5'h1F, 5'h00);
        run_to(FRAME, 8); tick();
        chk("held_old", bus_if.seg_out, 7'b0000001);
        run_to(FRAME, 1); tick();
        chk("new_after_boundary", bus_if.seg_out, 7'b0111000);

        // Two loads in one frame: last wins.
        run_to(FRAME, 10);
        do_load(20'h43215, 5'h00, 5'h1F, 5'h00);
        run_to(FRAME, 40);
        do_load(20'h4321A, 5'h00, 5'h1F, 5'h00);
        run_to(FRAME, 1); tick();
        chk("last_load_wins", bus_if.seg_out, 7'b0001000);

        // Load on the boundary cycle goes straight to the display.
        run_to(FRAME, FRAME - 1);
        do_load(20'h4321E, 5'h00, 5'h1F, 5'h00);
        tick(); tick();
        chk("boundary_load", bus_if.seg_out, 7'b0110000);

        // Brightness sweep, applied live.
        for (int b = 0; b < 3; b++) begin
            run_to(FRAME, 0);
            bus_if.brightness = 2'(b);
            clear_counts();
            repeat (FRAME) tick();
            for (int i = 0; i < ND; i++) chk("lit_brightness", lit_cnt[i], 4 * b + 3);
        end
        bus_if.brightness = 2'd3;

        // Blink on digit 2 over one full blink/frame super-period.
        do_load(20'h43210, 5'h00, 5'h1F, 5'h04);
        run_to(FRAME, 0);
        run_to(FRAME * 16, 0);
        clear_counts();
        repeat (FRAME * 16) tick();
        exp2 = 0;
        for (int k = 0; k < 16; k++)
            if (((FRAME * k + 2 * SLOT) % BLINK) < BLINK / 2) exp2 += 15;
        chk("blink_d2", lit_cnt[2], exp2);
        chk("blink_d1_steady", lit_cnt[1], 16 * 15);

        // Disabled digit stays dark.
        do_load(20'h43210, 5'h00, 5'h1B, 5'h04);
        run_to(FRAME, 0);
        clear_counts();
        repeat (FRAME) tick();
        chk("disabled_d2", lit_cnt[2], 0);
        chk("enabled_d0", lit_cnt[0], 15);

        // Decimal point only on digit 1.
        do_load(20'h43210, 5'h02, 5'h1F, 5'h00);
        run_to(FRAME, 0);
        clear_counts();
        repeat (FRAME) tick();
        chk("dp_lit", dp_lit, 15);
        chk("dp_stray", dp_stray, 0);

        // Random loads and brightness changes against the model.
        repeat (2000) begin
            if ($urandom_range(0, 29) == 0) begin
                bus_if.load      = 1'b1;
                bus_if.digits_in = 20'($urandom);
                bus_if.dp_in     = 5'($urandom);
                bus_if.enable_in = 5'($urandom);
                bus_if.blink_in  = 5'($urandom);
            end else begin
                bus_if.load = 1'b0;
            end
            if ($urandom_range(0, 99) == 0) bus_if.brightness = 2'($urandom_range(0, 3));
            tick();
        end
        bus_if.load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
